rice_core_decode_stage: RTL and testbench
=========================================

Name: rice_core_decode_stage

Overview:
- Instruction-decode stage of the rice core pipeline, directly upstream of the execute stage.
- Takes fetched instructions over a valid/ready handshake and decodes RV32I fields and immediates.
- Reads rs1/rs2 from the register-file array, bypassing the execute-result write-back of the same cycle.
- Blocks on register hazards and registers one decoded instruction for execute.

Parameters:
XLEN, 32, data/PC width in bits.

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_flush  input  1  kill held and incoming instruction (branch/exception redirect)
i_if_valid  input  1  fetch offers an instruction
o_if_ready  output  1  decode accepts the offered instruction this cycle
i_if_pc  input  XLEN  PC of the offered instruction
i_if_inst  input  32  offered instruction word
i_register_file  input  32*XLEN  current architectural registers (x0 reads 0)
i_exe_result_valid  input  1  execute writes rd this cycle
i_exe_result_rd  input  5  destination of that write
i_exe_result_value  input  XLEN  value written
i_exe_pending_valid  input  1  execute holds an instruction whose result is not yet available
i_exe_pending_rd  input  5  rd of that pending instruction
o_id_valid  output  1  decoded instruction available
i_id_ready  input  1  execute accepts it
o_id_pc  output  XLEN  PC
o_id_inst  output  32  raw instruction word
o_id_rd  output  5  destination; 0 when the instruction writes no register
o_id_rs1_value  output  XLEN  operand 1
o_id_rs2_value  output  XLEN  operand 2
o_id_imm  output  XLEN  sign-extended immediate
o_id_illegal  output  1  opcode not RV32I

Behaviour:
- Reset: o_id_valid=0; all other o_id_* outputs = 0. Reset has immediate effect, including mid-transfer.
- Accept: transfer occurs on i_if_valid && o_if_ready.
  - o_if_ready = !i_flush && !hazard && (!o_id_valid || i_id_ready).
  - Combinational from i_id_ready; no bubble on back-to-back transfers.
- Latency: one cycle. Decoded fields appear on o_id_* on the clock edge that completes the transfer.
- Hold: while o_id_valid && !i_id_ready, every o_id_* output is held stable.
- Drain: when o_id_valid && i_id_ready and no new transfer, o_id_valid falls next cycle.
- Register-use decode:
  - rd written: OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR. Otherwise o_id_rd=0.
  - rs1 used: all except LUI, AUIPC, JAL.
  - rs2 used: OP, STORE, BRANCH.
- Immediates: I, S, B, U, J formats, sign-extended to XLEN.
  - B and J immediates have bit0=0.
  - R-type immediate = 0.
- Illegal opcode: o_id_illegal=1, o_id_rd=0, no hazard check; the instruction is passed on.
- Operand read:
  - Value = i_register_file[rs] in the transfer cycle.
  - If i_exe_result_valid && rs==i_exe_result_rd && rs!=0, use i_exe_result_value instead (bypass).
  - rs==0 always yields 0.
  - An unused rs yields 0.
- Hazard: raised when a used nonzero rs equals either:
  - o_id_rd, while o_id_valid && o_id_rd!=0, or
  - i_exe_pending_rd, while i_exe_pending_valid.
  - An exe_result bypass match does not clear a pending hazard; pending wins.
- Hazard effect: o_if_ready=0. If the held instruction is consumed while stalled, o_id_valid drops to 0 (bubble).
- Flush:
  - o_if_ready=0 that cycle.
  - o_id_valid=0 next cycle regardless of i_id_ready.
  - Nothing captured.
  - Flush on the same cycle as a would-be transfer: flush wins.

Decomposition:
- rice_core_pkg:
  - opcode enum (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, MISC_MEM, SYSTEM)
  - rice_core_rd type
  - decoded-instruction struct (pc, inst, rd, rs values, imm, illegal)
  - immediate-format enum
- Sub-module rice_core_immediate_generator: combinational; instruction word -> imm and used-rs flags.

Test Plan:
1. Reset mid-transfer: assert i_rst_n=0 while o_id_valid=1 -> o_id_valid=0 immediately, all o_id_* = 0.
2. ADDI x5,x1,7 with x1=0x10 -> next cycle o_id_rd=5, o_id_rs1_value=0x10, o_id_imm=7, o_if_ready was 1.
3. Bypass: ADD x3,x1,x2 while exe writes x2=0xAB, register file x2=0 -> o_id_rs2_value=0xAB.
4. Write to x0 is ignored: exe writes rd=0 value 5, instruction reads x0 -> operand 0.
5. Back-to-back dependence: ADDI x4,.. held, then ADD x6,x4,x4 offered -> o_if_ready=0 until x4 leaves ID and pending clears; then accepted with bypassed value.
6. Load-use: i_exe_pending rd=4 and offered SW x4 -> stalled. Backpressure i_id_ready=0 for 3 cycles -> outputs stable. i_flush=1 -> o_id_valid=0 next cycle, offered instruction not captured.

Source files
------------

// File: rtl/rice_core_pkg.sv
// Shared types for the rice core: opcodes, immediate formats, the decoded-instruction payload
// and the register-hazard helper.
package rice_core_pkg;

   localparam int unsigned RICE_XLEN  = 32;
   localparam int unsigned INST_W     = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 32;

   typedef logic [REG_ADDR_W-1:0] rice_core_rd_t;

   typedef enum logic [6:0] {
      OPC_OP       = 7'b0110011,
      OPC_OP_IMM   = 7'b0010011,
      OPC_LOAD     = 7'b0000011,
      OPC_STORE    = 7'b0100011,
      OPC_BRANCH   = 7'b1100011,
      OPC_JAL      = 7'b1101111,
      OPC_JALR     = 7'b1100111,
      OPC_LUI      = 7'b0110111,
      OPC_AUIPC    = 7'b0010111,
      OPC_MISC_MEM = 7'b0001111,
      OPC_SYSTEM   = 7'b1110011
   } opcode_e;

   typedef enum logic [2:0] {
      FMT_R,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J,
      FMT_NONE
   } imm_fmt_e;

   typedef struct packed {
      logic [RICE_XLEN-1:0] pc;
      logic [INST_W-1:0]    inst;
      rice_core_rd_t        rd;
      logic [RICE_XLEN-1:0] rs1_value;
      logic [RICE_XLEN-1:0] rs2_value;
      logic [RICE_XLEN-1:0] imm;
      logic                 illegal;
   } decoded_t;

   // A used, nonzero source collides with the instruction in ID or the one pending in execute.
   function automatic logic rs_hazard(input logic          used,
                                      input rice_core_rd_t rs,
                                      input logic          id_valid,
                                      input rice_core_rd_t id_rd,
                                      input logic          pend_valid,
                                      input rice_core_rd_t pend_rd);
      logic id_hit;
      logic pend_hit;
      id_hit   = id_valid && (id_rd != '0) && (rs == id_rd);
      pend_hit = pend_valid && (rs == pend_rd);
      return used && (rs != '0) && (id_hit || pend_hit);
   endfunction

endpackage

// File: rtl/rice_core_immediate_generator.sv
// Combinational RV32I opcode classifier: immediate value, register-use flags, illegal opcode.
module rice_core_immediate_generator
   import rice_core_pkg::*;
#(
   parameter int unsigned XLEN = RICE_XLEN
) (
   input  logic [INST_W-1:0] inst,
   output logic [XLEN-1:0]   imm,
   output logic              rs1_used,
   output logic              rs2_used,
   output logic              rd_used,
   output logic              illegal
);

   imm_fmt_e    fmt;
   logic [31:0] imm32;

   always_comb begin
      fmt      = FMT_NONE;
      rs1_used = 1'b0;
      rs2_used = 1'b0;
      rd_used  = 1'b0;
      illegal  = 1'b0;
      case (opcode_e'(inst[6:0]))
         OPC_OP: begin
            fmt = FMT_R; rs1_used = 1'b1; rs2_used = 1'b1; rd_used = 1'b1;
         end
         OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
            fmt = FMT_I; rs1_used = 1'b1; rd_used = 1'b1;
         end
         OPC_STORE: begin
            fmt = FMT_S; rs1_used = 1'b1; rs2_used = 1'b1;
         end
         OPC_BRANCH: begin
            fmt = FMT_B; rs1_used = 1'b1; rs2_used = 1'b1;
         end
         OPC_JAL: begin
            fmt = FMT_J; rd_used = 1'b1;
         end
         OPC_LUI, OPC_AUIPC: begin
            fmt = FMT_U; rd_used = 1'b1;
         end
         OPC_MISC_MEM, OPC_SYSTEM: begin
            fmt = FMT_I; rs1_used = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

   // B and J immediates carry an implicit zero LSB.
   always_comb begin
      imm32 = '0;
      case (fmt)
         FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
         FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         FMT_U:   imm32 = {inst[31:12], 12'b0};
         FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/rice_core_decode_stage.sv
// Rice core decode stage: accepts fetched instructions, reads/bypasses operands, stalls on
// register hazards and holds one decoded instruction for execute.
module rice_core_decode_stage
   import rice_core_pkg::*;
#(
   parameter int unsigned XLEN = RICE_XLEN
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_flush,
   input  logic                     i_if_valid,
   output logic                     o_if_ready,
   input  logic [XLEN-1:0]          i_if_pc,
   input  logic [INST_W-1:0]        i_if_inst,
   input  logic [NUM_REGS*XLEN-1:0] i_register_file,
   input  logic                     i_exe_result_valid,
   input  logic [REG_ADDR_W-1:0]    i_exe_result_rd,
   input  logic [XLEN-1:0]          i_exe_result_value,
   input  logic                     i_exe_pending_valid,
   input  logic [REG_ADDR_W-1:0]    i_exe_pending_rd,
   output logic                     o_id_valid,
   input  logic                     i_id_ready,
   output logic [XLEN-1:0]          o_id_pc,
   output logic [INST_W-1:0]        o_id_inst,
   output logic [REG_ADDR_W-1:0]    o_id_rd,
   output logic [XLEN-1:0]          o_id_rs1_value,
   output logic [XLEN-1:0]          o_id_rs2_value,
   output logic [XLEN-1:0]          o_id_imm,
   output logic                     o_id_illegal
);

   logic [XLEN-1:0] regs [NUM_REGS];
   logic [XLEN-1:0] imm;
   logic            rs1_used;
   logic            rs2_used;
   logic            rd_used;
   logic            illegal;
   rice_core_rd_t   rs1;
   rice_core_rd_t   rs2;
   logic [XLEN-1:0] rs1_value;
   logic [XLEN-1:0] rs2_value;
   logic            hazard;
   logic            transfer;
   logic            id_valid_q;
   decoded_t        id_q;
   decoded_t        id_d;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
      assign regs[g] = i_register_file[g*XLEN +: XLEN];
   end

   rice_core_immediate_generator #(.XLEN(XLEN)) u_imm_gen (
      .inst     (i_if_inst),
      .imm      (imm),
      .rs1_used (rs1_used),
      .rs2_used (rs2_used),
      .rd_used  (rd_used),
      .illegal  (illegal)
   );

   assign rs1 = i_if_inst[19:15];
   assign rs2 = i_if_inst[24:20];

   // Unused or x0 sources read as zero; a same-cycle execute write-back overrides the array.
   always_comb begin
      rs1_value = '0;
      rs2_value = '0;
      if (rs1_used && (rs1 != '0)) begin
         rs1_value = (i_exe_result_valid && (i_exe_result_rd == rs1)) ? i_exe_result_value
                                                                      : regs[rs1];
      end
      if (rs2_used && (rs2 != '0)) begin
         rs2_value = (i_exe_result_valid && (i_exe_result_rd == rs2)) ? i_exe_result_value
                                                                      : regs[rs2];
      end
   end

   assign hazard = rs_hazard(rs1_used, rs1, id_valid_q, id_q.rd,
                             i_exe_pending_valid, i_exe_pending_rd)
                || rs_hazard(rs2_used, rs2, id_valid_q, id_q.rd,
                             i_exe_pending_valid, i_exe_pending_rd);

   assign o_if_ready = !i_flush && !hazard && (!id_valid_q || i_id_ready);
   assign transfer   = i_if_valid && o_if_ready;

   always_comb begin
      id_d           = '0;
      id_d.pc        = i_if_pc;
      id_d.inst      = i_if_inst;
      id_d.rd        = rd_used ? i_if_inst[11:7] : '0;
      id_d.rs1_value = rs1_value;
      id_d.rs2_value = rs2_value;
      id_d.imm       = imm;
      id_d.illegal   = illegal;
   end

   // Payload only changes on a transfer, so it is stable whenever execute back-pressures.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         id_valid_q <= 1'b0;
         id_q       <= '0;
      end else if (i_flush) begin
         id_valid_q <= 1'b0;
      end else if (transfer) begin
         id_valid_q <= 1'b1;
         id_q       <= id_d;
      end else if (i_id_ready) begin
         id_valid_q <= 1'b0;
      end
   end

   assign o_id_valid     = id_valid_q;
   assign o_id_pc        = id_q.pc;
   assign o_id_inst      = id_q.inst;
   assign o_id_rd        = id_q.rd;
   assign o_id_rs1_value = id_q.rs1_value;
   assign o_id_rs2_value = id_q.rs2_value;
   assign o_id_imm       = id_q.imm;
   assign o_id_illegal   = id_q.illegal;

endmodule

// File: tb/tb_rice_core_decode_stage.sv
// Self-checking bench for rice_core_decode_stage: directed scenarios followed by randomized
// traffic, checked against an opcode-table reference model.
module tb_rice_core_decode_stage;

   logic          i_clk;
   logic          i_rst_n;
   logic          i_flush;
   logic          i_if_valid;
   logic          o_if_ready;
   logic [31:0]   i_if_pc;
   logic [31:0]   i_if_inst;
   logic [1023:0] i_register_file;
   logic          i_exe_result_valid;
   logic [4:0]    i_exe_result_rd;
   logic [31:0]   i_exe_result_value;
   logic          i_exe_pending_valid;
   logic [4:0]    i_exe_pending_rd;
   logic          o_id_valid;
   logic          i_id_ready;
   logic [31:0]   o_id_pc;
   logic [31:0]   o_id_inst;
   logic [4:0]    o_id_rd;
   logic [31:0]   o_id_rs1_value;
   logic [31:0]   o_id_rs2_value;
   logic [31:0]   o_id_imm;
   logic          o_id_illegal;

   logic [31:0] rf [32];

   int total  = 0;
   int passed = 0;
   int failed = 0;

   // expected contents of the ID register
   bit          ev;
   logic [31:0] e_pc, e_inst, e_rs1, e_rs2, e_imm;
   logic [4:0]  e_rd;
   bit          e_ill;

   rice_core_decode_stage #(.XLEN(32)) dut (
      .i_clk               (i_clk),
      .i_rst_n             (i_rst_n),
      .i_flush             (i_flush),
      .i_if_valid          (i_if_valid),
      .o_if_ready          (o_if_ready),
      .i_if_pc             (i_if_pc),
      .i_if_inst           (i_if_inst),
      .i_register_file     (i_register_file),
      .i_exe_result_valid  (i_exe_result_valid),
      .i_exe_result_rd     (i_exe_result_rd),
      .i_exe_result_value  (i_exe_result_value),
      .i_exe_pending_valid (i_exe_pending_valid),
      .i_exe_pending_rd    (i_exe_pending_rd),
      .o_id_valid          (o_id_valid),
      .i_id_ready          (i_id_ready),
      .o_id_pc             (o_id_pc),
      .o_id_inst           (o_id_inst),
      .o_id_rd             (o_id_rd),
      .o_id_rs1_value      (o_id_rs1_value),
      .o_id_rs2_value      (o_id_rs2_value),
      .o_id_imm            (o_id_imm),
      .o_id_illegal        (o_id_illegal)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   always_comb begin
      for (int i = 0; i < 32; i++) i_register_file[i*32 +: 32] = rf[i];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference decode from the RV32I opcode table; immediates via arithmetic shifts.
   function automatic void ref_decode(input logic [31:0] inst, output bit legal, output bit wr,
                                      output bit u1, output bit u2, output logic [31:0] imm);
      logic [6:0]         opc;
      logic signed [31:0] s;
      opc   = inst[6:0];
      s     = $signed(inst);
      legal = opc inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17,
                          7'h0F, 7'h73};
      wr    = opc inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67};
      u1    = legal && !(opc inside {7'h37, 7'h17, 7'h6F});
      u2    = opc inside {7'h33, 7'h23, 7'h63};
      if (opc inside {7'h13, 7'h03, 7'h67, 7'h0F, 7'h73})
         imm = 32'(s >>> 20);
      else if (opc == 7'h23)
         imm = 32'((s >>> 25) <<< 5) | 32'(inst[11:7]);
      else if (opc == 7'h63)
         imm = 32'((s >>> 31) <<< 12) | (32'(inst[7]) << 11) | (32'(inst[30:25]) << 5)
             | (32'(inst[11:8]) << 1);
      else if (opc inside {7'h37, 7'h17})
         imm = inst & 32'hFFFF_F000;
      else if (opc == 7'h6F)
         imm = 32'((s >>> 31) <<< 20) | (32'(inst[19:12]) << 12) | (32'(inst[20]) << 11)
             | (32'(inst[30:21]) << 1);
      else
         imm = 32'h0;
   endfunction

   function automatic bit ref_hz(input bit u, input logic [4:0] rs);
      return u && (rs != 0) && ((ev && (e_rd != 0) && (rs == e_rd))
                                || (i_exe_pending_valid && (rs == i_exe_pending_rd)));
   endfunction

   function automatic logic [31:0] ref_opnd(input bit u, input logic [4:0] rs);
      if (!u || rs == 0) return 32'h0;
      if (i_exe_result_valid && (i_exe_result_rd == rs)) return i_exe_result_value;
      return rf[rs];
   endfunction

   function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, 3'b000, rd, opc};
   endfunction

   function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
   endfunction

   function automatic logic [31:0] enc_s(input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [11:0] imm);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
   endfunction

   task automatic check_outputs();
      chk("id_valid", 32'(o_id_valid), 32'(ev));
      if (ev) begin
         chk("id_pc", o_id_pc, e_pc);
         chk("id_inst", o_id_inst, e_inst);
         chk("id_rd", 32'(o_id_rd), 32'(e_rd));
         chk("id_rs1", o_id_rs1_value, e_rs1);
         chk("id_rs2", o_id_rs2_value, e_rs2);
         chk("id_imm", o_id_imm, e_imm);
         chk("id_illegal", 32'(o_id_illegal), 32'(e_ill));
      end
   endtask

   task automatic check_reset_zero(input string tag);
      chk({tag, "_valid"}, 32'(o_id_valid), 32'h0);
      chk({tag, "_pc"}, o_id_pc, 32'h0);
      chk({tag, "_inst"}, o_id_inst, 32'h0);
      chk({tag, "_rd"}, 32'(o_id_rd), 32'h0);
      chk({tag, "_rs1"}, o_id_rs1_value, 32'h0);
      chk({tag, "_rs2"}, o_id_rs2_value, 32'h0);
      chk({tag, "_imm"}, o_id_imm, 32'h0);
      chk({tag, "_illegal"}, 32'(o_id_illegal), 32'h0);
   endtask

   task automatic model_reset();
      ev = 0; e_pc = '0; e_inst = '0; e_rs1 = '0; e_rs2 = '0; e_imm = '0; e_rd = '0; e_ill = 0;
   endtask

   // Called just after a rising edge with inputs set; checks ready, advances one cycle.
   task automatic tick();
      bit          legal, wr, u1, u2, rdy;
      logic [31:0] imm;
      logic [4:0]  rs1, rs2;
      ref_decode(i_if_inst, legal, wr, u1, u2, imm);
      rs1 = i_if_inst[19:15];
      rs2 = i_if_inst[24:20];
      rdy = !i_flush && !ref_hz(u1, rs1) && !ref_hz(u2, rs2) && (!ev || i_id_ready);
      @(negedge i_clk);
      chk("if_ready", 32'(o_if_ready), 32'(rdy));
      if (i_flush) ev = 0;
      else if (rdy && i_if_valid) begin
         ev     = 1;
         e_pc   = i_if_pc;
         e_inst = i_if_inst;
         e_rd   = (legal && wr) ? i_if_inst[11:7] : 5'd0;
         e_rs1  = ref_opnd(u1, rs1);
         e_rs2  = ref_opnd(u2, rs2);
         e_imm  = imm;
         e_ill  = !legal;
      end else if (i_id_ready) ev = 0;
      @(posedge i_clk);
      #1;
      check_outputs();
   endtask

   initial begin
      logic [6:0] opcs [12];
      opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73,
               7'h5B};
      i_rst_n = 0; i_flush = 0; i_if_valid = 0; i_if_pc = '0; i_if_inst = '0;
      i_exe_result_valid = 0; i_exe_result_rd = '0; i_exe_result_value = '0;
      i_exe_pending_valid = 0; i_exe_pending_rd = '0; i_id_ready = 0;
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      rf[0] = 32'hDEAD_BEEF;
      rf[1] = 32'h10;
      rf[2] = 32'h0;
      model_reset();
      repeat (2) @(posedge i_clk);
      #1;
      check_reset_zero("reset");
      @(negedge i_clk);
      i_rst_n = 1;
      @(posedge i_clk);
      #1;

      // ADDI x5,x1,7
      i_id_ready = 1; i_if_valid = 1; i_if_pc = 32'h100;
      i_if_inst = enc_i(7'h13, 5'd5, 5'd1, 12'd7);
      tick();
      chk("addi_rd", 32'(o_id_rd), 32'd5);
      chk("addi_rs1", o_id_rs1_value, 32'h10);
      chk("addi_imm", o_id_imm, 32'd7);

      // ADD x3,x1,x2 with same-cycle write-back of x2
      i_if_pc = 32'h104; i_if_inst = enc_r(5'd3, 5'd1, 5'd2);
      i_exe_result_valid = 1; i_exe_result_rd = 5'd2; i_exe_result_value = 32'hAB;
      tick();
      chk("bypass_rs2", o_id_rs2_value, 32'hAB);

      // write-back to x0 must not reach an x0 read
      i_if_pc = 32'h108; i_if_inst = enc_i(7'h13, 5'd8, 5'd0, 12'd3);
      i_exe_result_rd = 5'd0; i_exe_result_value = 32'd5;
      tick();
      chk("x0_read", o_id_rs1_value, 32'h0);
      i_exe_result_valid = 0;

      // back-to-back dependence through x4
      i_if_pc = 32'h10C; i_if_inst = enc_i(7'h13, 5'd4, 5'd1, 12'd1);
      tick();
      i_id_ready = 0; i_if_pc = 32'h110; i_if_inst = enc_r(5'd6, 5'd4, 5'd4);
      tick();
      chk("dep_held_pc", o_id_pc, 32'h10C);
      i_id_ready = 1; i_exe_pending_valid = 1; i_exe_pending_rd = 5'd4;
      tick();
      chk("dep_bubble", 32'(o_id_valid), 32'h0);
      i_exe_pending_valid = 0;
      i_exe_result_valid = 1; i_exe_result_rd = 5'd4; i_exe_result_value = 32'h11;
      tick();
      chk("dep_rs1", o_id_rs1_value, 32'h11);
      chk("dep_rs2", o_id_rs2_value, 32'h11);
      chk("dep_rd", 32'(o_id_rd), 32'd6);
      i_exe_result_valid = 0;

      // load-use stall under back-pressure, then flush
      i_if_pc = 32'h114; i_if_inst = enc_i(7'h13, 5'd9, 5'd1, 12'hFFB);
      tick();
      chk("neg_imm", o_id_imm, 32'hFFFF_FFFB);
      i_exe_pending_valid = 1; i_exe_pending_rd = 5'd4; i_id_ready = 0;
      i_if_pc = 32'h118; i_if_inst = enc_s(5'd1, 5'd4, 12'd8);
      repeat (3) tick();
      chk("stall_held_pc", o_id_pc, 32'h114);
      i_flush = 1;
      tick();
      chk("flush_valid", 32'(o_id_valid), 32'h0);
      i_flush = 0; i_exe_pending_valid = 0; i_if_valid = 0;
      tick();
      chk("flush_not_captured", 32'(o_id_valid), 32'h0);

      // illegal opcode passes through with no destination
      i_if_valid = 1; i_id_ready = 1; i_if_pc = 32'h11C; i_if_inst = 32'hFFFF_FFFF;
      tick();
      chk("illegal_flag", 32'(o_id_illegal), 32'h1);
      chk("illegal_rd", 32'(o_id_rd), 32'h0);

      // reset while an instruction is held
      i_id_ready = 0;
      tick();
      #3 i_rst_n = 0;
      #1;
      check_reset_zero("midreset");
      model_reset();
      i_if_valid = 0;
      @(negedge i_clk);
      i_rst_n = 1;
      @(posedge i_clk);
      #1;
      check_outputs();

      // randomized traffic, registers confined to x0..x7 to provoke hazards
      for (int n = 0; n < 400; n++) begin
         logic [31:0] inst;
         inst        = $urandom;
         inst[6:0]   = opcs[$urandom_range(0, 11)];
         inst[11:7]  = 5'($urandom_range(0, 7));
         inst[19:15] = 5'($urandom_range(0, 7));
         inst[24:20] = 5'($urandom_range(0, 7));
         i_if_inst           = inst;
         i_if_pc             = $urandom & 32'hFFFF_FFFC;
         i_if_valid          = ($urandom_range(0, 3) != 0);
         i_id_ready          = ($urandom_range(0, 3) != 0);
         i_flush             = ($urandom_range(0, 15) == 0);
         i_exe_result_valid  = ($urandom_range(0, 1) != 0);
         i_exe_result_rd     = 5'($urandom_range(0, 7));
         i_exe_result_value  = $urandom;
         i_exe_pending_valid = ($urandom_range(0, 3) == 0);
         i_exe_pending_rd    = 5'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) rf[$urandom_range(1, 31)] = $urandom;
         tick();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
